add_round_key: RTL and testbench

AES AddRoundKey stage: XORs a 128-bit cipher state with a 128-bit round key, one block per transfer. Sits between MixColumns (or the input whitening step) and the next round in the AES datapath. It is used by both the cipher and the inverse cipher, since XOR is self-inverse. The stage is a registered valid/ready pipeline element with a two-entry skid buffer, so it sustains one block per cycle under backpressure.

---
 rtl/add_round_key.sv | 82 ++++++++
 tb/tb_add_round_key.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key.sv
// add_round_key: AES AddRoundKey, state_out = state_in ^ round_key, one block per transfer.
// Latency: 1 cycle from accept to out_valid; sustains 1 block/cycle while out_ready=1.
// Backpressure: main + skid register pair; in_ready is purely registered and drops once skid holds a block.
module add_round_key #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] state_in,
  input  logic [DATA_W-1:0] round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] state_out
);

  // main drives the output, skid catches the one beat accepted while main stalls
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_valid_q, skid_valid_d;

  logic              acc;
  logic              drain;
  logic [DATA_W-1:0] beat_dat;

  // ready comes only from registered state so there is no out_ready -> in_ready path
  assign in_ready  = !skid_valid_q && !rst;
  assign out_valid = main_valid_q;
  assign state_out = main_data_q;

  assign acc   = in_valid && in_ready;
  assign drain = main_valid_q && out_ready;

  // gate the XOR with the handshake so undriven inputs on idle cycles never reach a register
  assign beat_dat = acc ? (state_in ^ round_key) : '0;

  // next-state for the main/skid pair; FIFO order is kept by always refilling main from skid first
  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        if (acc) begin
          skid_data_d  = beat_dat;
          skid_valid_d = 1'b1;
        end
      end else if (acc) begin
        main_data_d  = beat_dat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_data_d  = beat_dat;
      skid_valid_d = 1'b1;
    end
  end

  // state registers; reset wins over any handshake on the same edge and discards in-flight blocks
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// tb_add_round_key: randomized and directed stimulus against a queue-based reference model.
// Latency: model expects each accepted block on the output one cycle later, in order.
// Backpressure: model is a 2-deep FIFO; in_ready expected high whenever fewer than 2 blocks are pending.
module tb_add_round_key;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] state_in = '0;
  logic [W-1:0] round_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           acc_log[$];
  int           out_log[$];
  logic [W-1:0] got_log[$];
  bit           rst_prev = 1'b1;
  bit           acc_b, drn_b;

  add_round_key #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: FIFO of expected results, at most 2 pending, updated on handshakes.
  always @(negedge clk) begin
    if (rst_prev) check("rst_state_out", state_out, '0);
    check("in_ready", W'(in_ready), W'(!rst && exp_q.size() < 2));
    check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("state_out", state_out, exp_q[0]);
    if (rst) begin
      exp_q.delete();
    end else begin
      acc_b = in_valid && in_ready;
      drn_b = out_valid && out_ready;
      if (drn_b) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        out_log.push_back(cyc);
        got_log.push_back(state_out);
      end
      if (acc_b) begin
        exp_q.push_back(state_in ^ round_key);
        acc_log.push_back(cyc);
      end
    end
    rst_prev = rst;
  end

  task automatic clear_logs();
    acc_log.delete();
    out_log.delete();
    got_log.delete();
  endtask

  task automatic step(input logic v, input logic [W-1:0] s, input logic [W-1:0] k, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    state_in  = s;
    round_key = k;
    out_ready = r;
  endtask

  task automatic single(input string tag, input logic [W-1:0] s, input logic [W-1:0] k,
                        input logic [W-1:0] exp);
    step(1'b1, s, k, 1'b1);
    step(1'b0, 'x, 'x, 1'b1);
    @(negedge clk);
    check({tag, "_vld"}, W'(out_valid), W'(1));
    check(tag, state_out, exp);
  endtask

  task automatic stream(input string tag, input int n, input int vld_pct, input int rdy_pct);
    logic [W-1:0] ss[$];
    logic [W-1:0] ks[$];
    int idx = 0;
    int budget = 0;
    bit v;
    clear_logs();
    for (int i = 0; i < n; i++) begin
      ss.push_back(rnd128());
      ks.push_back(rnd128());
    end
    while (idx < n && budget < 20 * n + 50) begin
      v = ($urandom_range(99) < vld_pct);
      step(v, v ? ss[idx] : 'x, v ? ks[idx] : 'x, $urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      budget++;
    end
    budget = 0;
    while (out_log.size() < n && budget < 20 * n + 50) begin
      step(1'b0, 'x, 'x, 1'b1);
      @(negedge clk);
      #1;
      budget++;
    end
    check({tag, "_count"}, W'(got_log.size()), W'(n));
    for (int i = 0; i < got_log.size() && i < n; i++)
      check({tag, "_data"}, got_log[i], ss[i] ^ ks[i]);
  endtask

  initial begin
    logic [W-1:0] bs[4];
    logic [W-1:0] bk[4];
    logic [W-1:0] held;
    logic [W-1:0] s;
    int idx;
    int budget;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_in_ready", W'(in_ready), W'(0));
    check("reset_state_out", state_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", W'(in_ready), W'(1));
    check("release_out_valid", W'(out_valid), W'(0));
    check("release_state_out", state_out, '0);

    // known-answer and algebraic vectors
    single("fips_vec", 128'h046681e5_e0cb199a_48f8d37a_2806264c,
           128'ha0fafe17_88542cb1_23a33939_2a6c7605, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
    single("self_inverse", 128'ha49c7ff2_689f352b_6b5bea43_026a5049,
           128'ha0fafe17_88542cb1_23a33939_2a6c7605, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    s = rnd128();
    single("identity", s, '0, s);
    single("complement", '0, '1, {W{1'b1}});
    s = rnd128();
    single("self_xor", s, s, '0);

    // backpressure: 3 stalled cycles with in_valid held high
    step(1'b0, 'x, 'x, 1'b1);
    step(1'b0, 'x, 'x, 1'b1);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      bs[i] = rnd128();
      bk[i] = rnd128();
    end
    idx = 0;
    held = '0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, bs[idx], bk[idx], 1'b0);
      @(negedge clk);
      if (c == 1) held = state_out;
      if (c == 2) check("bp_stable", state_out, held);
      if (in_valid && in_ready) idx++;
    end
    check("bp_accepted", W'(idx), W'(2));
    check("bp_in_ready_low", W'(in_ready), W'(0));
    check("bp_head", state_out, bs[0] ^ bk[0]);
    budget = 0;
    while ((idx < 4 || out_log.size() < 4) && budget < 40) begin
      step(idx < 4, bs[idx < 4 ? idx : 3], bk[idx < 4 ? idx : 3], 1'b1);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      #1;
      budget++;
    end
    check("bp_timeout", W'(budget < 40), W'(1));
    check("bp_count", W'(out_log.size()), W'(4));
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("bp_order", got_log[i], bs[i] ^ bk[i]);
      check("bp_no_gap", W'(out_log[i]), W'(out_log[0] + i));
    end

    // full throughput
    stream("thru", 16, 100, 100);
    check("thru_acc_count", W'(acc_log.size()), W'(16));
    if (acc_log.size() == 16 && out_log.size() == 16) begin
      check("thru_latency", W'(out_log[0]), W'(acc_log[0] + 1));
      for (int i = 1; i < 16; i++) begin
        check("thru_acc_consec", W'(acc_log[i]), W'(acc_log[0] + i));
        check("thru_out_consec", W'(out_log[i]), W'(out_log[0] + i));
      end
    end

    // randomized valid/ready traffic
    stream("random", 200, 70, 60);

    // reset with both registers full
    step(1'b1, rnd128(), rnd128(), 1'b0);
    step(1'b1, rnd128(), rnd128(), 1'b0);
    step(1'b1, rnd128(), rnd128(), 1'b0);
    @(negedge clk);
    check("mid_full_in_ready", W'(in_ready), W'(0));
    check("mid_full_out_valid", W'(out_valid), W'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_state_out", state_out, '0);
    check("mid_rst_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", W'(in_ready), W'(1));
    check("mid_rel_out_valid", W'(out_valid), W'(0));
    check("mid_rel_state_out", state_out, '0);
    clear_logs();
    repeat (4) step(1'b0, 'x, 'x, 1'b1);
    @(negedge clk);
    #1;
    check("mid_no_stale", W'(out_log.size()), W'(0));

    // stream recovers after reset
    stream("post_rst", 8, 100, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", W'(0), W'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
